router_pkt_fifo: RTL and testbench
==================================

# router_pkt_fifo

Parametrised, packet-aware synchronous FIFO; next-generation output buffer for the router's 1x3 output channels. Stores each byte with a header tag and tracks the remaining bytes of the packet being read, so the downstream side gets explicit valid, start-of-packet and end-of-packet strobes. Depth and width are configurable. It adds almost-full back-pressure and overflow/underflow error pulses. One instance sits between the router register block and each destination port.

## Interface

Parameters:

- DATA_W, 8: byte width; must be ≥ 4. Header layout: length field is [DATA_W-1:2], address is [1:0].
- DEPTH, 16: entries; power of 2, ≥ 4. AW = log2(DEPTH).
- AFULL_TH, DEPTH-2: `almost_full` asserts when occupancy ≥ AFULL_TH.

Ports (clock and reset first):

- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- soft_reset  in  1  synchronous clear (timeout flush from the FSM).
- write_enb  in  1  write request.
- read_enb  in  1  read request.
- lfd_state_in  in  1  header-byte marker from the router FSM.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  registered read data.
- data_valid  out  1  `data_out` carries a newly read byte this cycle.
- sop  out  1  with `data_valid`: the byte is a header.
- eop  out  1  with `data_valid`: the byte is the last byte of the packet (parity).
- empty  out  1  no entries.
- full  out  1  DEPTH entries.
- almost_full  out  1  occupancy ≥ AFULL_TH.
- ovf_err  out  1  one-cycle pulse: write attempted while full.
- udf_err  out  1  one-cycle pulse: read attempted while empty.

## Operation

- **Storage:** DEPTH × (DATA_W+1) array holding {hdr_tag, data}. Pointers are AW+1 bits with a wrap bit.
  - `empty` = pointers equal.
  - `full` = addresses equal and wrap bits differ.
  - Both are combinational from registered pointers.
- **Header tag:** `lfd_state_in` is registered once (lfd_q). The tag stored by a write at cycle N is `lfd_state_in` sampled at cycle N-1, which matches router FSM timing.
- **Write:** accepted iff `write_enb` && !`full`.
  - `write_enb` && `full` drops the data and pulses `ovf_err`.
- **Read:** accepted iff `read_enb` && !`empty`.
  - `read_enb` && `empty` pulses `udf_err` and leaves `data_out` unchanged.
- **Simultaneous read and write:** both are evaluated against pre-edge flags.
  - When full: the read proceeds, the write is dropped with `ovf_err`, and occupancy becomes DEPTH-1.
  - When empty: the write proceeds, the read gives `udf_err`, and occupancy becomes 1.
- **Packet counter** `rem` (DATA_W-1 bits):
  - On an accepted read of a tagged entry: `rem` ← length field + 1 (payload plus parity) and `sop`=1.
  - On an accepted read of an untagged entry with `rem` ≠ 0: `rem` decrements.
  - `eop`=1 when that decrement takes `rem` from 1 to 0.
  - Untagged read with `rem`=0 (orphan byte): delivered with `data_valid`=1, `sop`=`eop`=0.
- **soft_reset** (priority below `rst`, above everything else): clears pointers, `rem`, lfd_q, `data_valid`, `sop`, `eop` and error pulses. `data_out` goes to 0. Array contents are don't-care.
- **No high-Z output:** idle `data_out` holds its last value.

## Timing

- Reset values (async `rst`=0): `data_out`=0; `data_valid`=`sop`=`eop`=0; `empty`=1; `full`=0; `almost_full`=0 (AFULL_TH>0); `ovf_err`=`udf_err`=0; pointers, `rem` and lfd_q = 0.
- Reset asserted mid-packet aborts immediately. Deassertion is sampled on `clk`; the first accepted write is in the first edge after release.
- Write to read latency:
  - A write at edge N makes `empty` fall after edge N.
  - The earliest read is at edge N+1, with `data_out`/`data_valid` visible after edge N+1.
  - Read latency is 1 cycle.
- `data_valid`, `sop`, `eop`, `ovf_err` and `udf_err` are single-cycle registered pulses aligned with `data_out`.
- Back-to-back reads deliver one byte per cycle with no bubbles.
- `almost_full` is combinational from pointers and updates in the same cycle as `full`.

## Configuration

- `ROUTER_PKT_FIFO_OCC_EN`:
  - Defined: adds output `fill_level` [AW:0] = wr_ptr − rd_ptr (modulo 2^(AW+1)); reset value 0; DEPTH when full.
  - Undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan

- Reset, then write header 0x0C (length 3) with lfd, then 3 payload bytes and parity 0xA5, then read 5 bytes → `sop` on byte 1, `eop` on 0xA5 only, `data_valid` 5 cycles, `empty`=1 at end.
- Write 16 bytes (DEPTH=16) → `full`=1, `almost_full` from the 14th write. 17th write → `ovf_err` pulse, contents unchanged. Read all 16 → same order across pointer wrap.
- With `full`=1, assert read+write together → one byte out, write dropped with `ovf_err`, `fill_level`=15 (OCC_EN). With `empty`=1, read+write together → `udf_err`, `empty`=0 next cycle.
- Mid-packet (`rem`=2), assert `soft_reset` for 1 cycle → `empty`=1, `data_out`=0, `data_valid`=0. Then a new header packet reads with correct `sop`/`eop`.
- Assert `rst` asynchronously between clock edges during a read burst → all outputs at reset values before the next edge.
- DATA_W=16, DEPTH=64 build: header length field 0x0005 → `eop` on the 7th byte read.

Source files
------------

// File: rtl/router_pkt_fifo.sv
// Packet-aware output FIFO: tags header bytes, emits sop/eop/valid strobes, almost-full
// back-pressure and overflow/underflow pulses. Define ROUTER_PKT_FIFO_OCC_EN for fill_level.
module router_pkt_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              sop,
    output logic              eop,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              ovf_err,
`ifdef ROUTER_PKT_FIFO_OCC_EN
    output logic [AW:0]       fill_level,
`endif
    output logic              udf_err
);

    localparam int PW = AW + 1;
    localparam int RW = DATA_W - 1;
    localparam int LW = DATA_W - 2;
    localparam logic [AW:0] AFULL_LVL = PW'(AFULL_TH);

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic              lfd_q, lfd_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic [AW:0]       occ;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W:0]   rd_entry;
    logic [LW-1:0]     rd_len;

    assign occ         = wr_ptr_q - rd_ptr_q;
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign almost_full = (occ >= AFULL_LVL);

    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
    assign rd_len   = rd_entry[DATA_W-1:2];

    // Both accept decisions use the pre-edge flags, so read+write on full drops the write.
    assign wr_acc = write_enb && !full && !soft_reset;
    assign rd_acc = read_enb && !empty && !soft_reset;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rem_d        = rem_q;
        lfd_d        = lfd_state_in;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        sop_d        = 1'b0;
        eop_d        = 1'b0;
        ovf_d        = write_enb && full;
        udf_d        = read_enb && empty;

        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            rem_d      = '0;
            lfd_d      = 1'b0;
            data_out_d = '0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d     = rd_ptr_q + PW'(1);
                data_out_d   = rd_entry[DATA_W-1:0];
                data_valid_d = 1'b1;
                if (rd_entry[DATA_W]) begin
                    // payload length plus the trailing parity byte
                    rem_d = {1'b0, rd_len} + RW'(1);
                    sop_d = 1'b1;
                end else if (rem_q != '0) begin
                    rem_d = rem_q - RW'(1);
                    eop_d = (rem_q == RW'(1));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rem_q        <= '0;
            lfd_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rem_q        <= rem_d;
            lfd_q        <= lfd_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
        end
    end

    // Storage needs no reset; the tag is the header marker seen one cycle earlier.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lfd_q, data_in};
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign sop        = sop_q;
    assign eop        = eop_q;
    assign ovf_err    = ovf_q;
    assign udf_err    = udf_q;

`ifdef ROUTER_PKT_FIFO_OCC_EN
    assign fill_level = occ;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Bench for router_pkt_fifo: queue-based packet model compared every cycle, plus directed
// literal checks of the packet, full/empty, soft-reset, async-reset and wide-build cases.
`timescale 1ns/1ps
module tb_router_pkt_fifo;

    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int AFT = DEP - 2;

    logic          clk;
    logic          rst;
    logic          soft_reset;
    logic          write_enb;
    logic          read_enb;
    logic          lfd;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          data_valid, sop, eop, empty, full, almost_full, ovf_err, udf_err;
`ifdef ROUTER_PKT_FIFO_OCC_EN
    logic [4:0]    fill_level;
`endif

    logic          w_sr, w_we, w_re, w_lfd;
    logic [15:0]   w_din, w_dout;
    logic          w_dv, w_sop, w_eop, w_empty, w_full, w_afull, w_ovf, w_udf;
`ifdef ROUTER_PKT_FIFO_OCC_EN
    logic [6:0]    w_fill;
`endif

    router_pkt_fifo #(.DATA_W(DW), .DEPTH(DEP), .AFULL_TH(AFT)) dut (
        .clk(clk), .rst(rst), .soft_reset(soft_reset), .write_enb(write_enb),
        .read_enb(read_enb), .lfd_state_in(lfd), .data_in(data_in), .data_out(data_out),
        .data_valid(data_valid), .sop(sop), .eop(eop), .empty(empty), .full(full),
        .almost_full(almost_full), .ovf_err(ovf_err),
`ifdef ROUTER_PKT_FIFO_OCC_EN
        .fill_level(fill_level),
`endif
        .udf_err(udf_err)
    );

    router_pkt_fifo #(.DATA_W(16), .DEPTH(64)) dut_wide (
        .clk(clk), .rst(rst), .soft_reset(w_sr), .write_enb(w_we),
        .read_enb(w_re), .lfd_state_in(w_lfd), .data_in(w_din), .data_out(w_dout),
        .data_valid(w_dv), .sop(w_sop), .eop(w_eop), .empty(w_empty), .full(w_full),
        .almost_full(w_afull), .ovf_err(w_ovf),
`ifdef ROUTER_PKT_FIFO_OCC_EN
        .fill_level(w_fill),
`endif
        .udf_err(w_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [DW:0]   mq[$];
    int            m_rem;
    bit            m_lfd;
    logic [DW-1:0] m_dout;
    bit            m_dv, m_sop, m_eop, m_ovf, m_udf;

    int n_chk;
    int n_pass;

    task automatic model_reset();
        mq.delete();
        m_rem  = 0;
        m_lfd  = 1'b0;
        m_dout = '0;
        m_dv   = 1'b0;
        m_sop  = 1'b0;
        m_eop  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic model_step();
        logic [DW:0] e;
        bit          was_empty;
        bit          was_full;
        if (soft_reset) begin
            model_reset();
            return;
        end
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() == DEP);
        m_dv  = 1'b0;
        m_sop = 1'b0;
        m_eop = 1'b0;
        m_ovf = write_enb && was_full;
        m_udf = read_enb && was_empty;
        if (read_enb && !was_empty) begin
            e      = mq.pop_front();
            m_dout = e[DW-1:0];
            m_dv   = 1'b1;
            if (e[DW]) begin
                m_rem = int'(e[DW-1:2]) + 1;
                m_sop = 1'b1;
            end else if (m_rem != 0) begin
                m_rem = m_rem - 1;
                m_eop = (m_rem == 0);
            end
        end
        if (write_enb && !was_full) mq.push_back({m_lfd, data_in});
        m_lfd = lfd;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic compare();
        chk("data_out",    32'(data_out),    32'(m_dout));
        chk("data_valid",  32'(data_valid),  32'(m_dv));
        chk("sop",         32'(sop),         32'(m_sop));
        chk("eop",         32'(eop),         32'(m_eop));
        chk("ovf_err",     32'(ovf_err),     32'(m_ovf));
        chk("udf_err",     32'(udf_err),     32'(m_udf));
        chk("empty",       32'(empty),       32'(mq.size() == 0));
        chk("full",        32'(full),        32'(mq.size() == DEP));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= AFT));
`ifdef ROUTER_PKT_FIFO_OCC_EN
        chk("fill_level",  32'(fill_level),  32'(mq.size()));
`endif
    endtask

    task automatic cyc(input bit we, input bit re, input bit lf, input logic [DW-1:0] d,
                       input bit sr);
        write_enb  = we;
        read_enb   = re;
        lfd        = lf;
        data_in    = d;
        soft_reset = sr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    logic [7:0] pkt_a [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'hA5};
    bit         sop_a [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bit         eop_a [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] pkt_b [4] = '{8'h08, 8'h77, 8'h78, 8'hC3};

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b0;
        soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0; lfd = 1'b0; data_in = '0;
        w_sr = 1'b0; w_we = 1'b0; w_re = 1'b0; w_lfd = 1'b0; w_din = '0;
        model_reset();
        repeat (3) @(negedge clk);

        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_valid",    32'(data_valid), 0);
        chk("rst_empty",    32'(empty), 1);
        chk("rst_full",     32'(full), 0);
        chk("rst_afull",    32'(almost_full), 0);
        chk("rst_w_empty",  32'({w_empty, w_full, w_afull, w_ovf, w_udf, w_dv}), 32'h20);
`ifdef ROUTER_PKT_FIFO_OCC_EN
        chk("rst_w_fill",   32'(w_fill), 0);
`endif
        compare();
        rst = 1'b1;

        // header 0x0C (length 3), three payload bytes, parity
        cyc(0, 0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, pkt_a[i], 0);
        chk("empty_after_wr", 32'(empty), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 8'h00, 0);
            chk("pkt_a_byte", 32'(data_out), 32'(pkt_a[i]));
            chk("pkt_a_sop",  32'(sop), 32'(sop_a[i]));
            chk("pkt_a_eop",  32'(eop), 32'(eop_a[i]));
            chk("pkt_a_dv",   32'(data_valid), 1);
        end
        cyc(0, 0, 0, 8'h00, 0);
        chk("pkt_a_empty", 32'(empty), 1);
        chk("dv_idle",     32'(data_valid), 0);
        chk("dout_hold",   32'(data_out), 32'h A5);
        cyc(0, 1, 0, 8'h00, 0);
        chk("udf_pulse",   32'(udf_err), 1);
        chk("udf_dout",    32'(data_out), 32'hA5);

        // fill to full across the pointer wrap, overflow, drain
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0, 8'(8'h41 + i), 0);
            if (i == 12) chk("afull_13", 32'(almost_full), 0);
            if (i == 13) chk("afull_14", 32'(almost_full), 1);
        end
        chk("full_16", 32'(full), 1);
        cyc(1, 0, 0, 8'hEE, 0);
        chk("ovf_pulse", 32'(ovf_err), 1);
        cyc(0, 0, 0, 8'h00, 0);
        chk("ovf_clear", 32'(ovf_err), 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0, 8'h00, 0);
            chk("drain_order", 32'(data_out), 32'(8'(8'h41 + i)));
        end
        chk("drain_empty", 32'(empty), 1);

        // simultaneous read+write on full, then on empty
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'($urandom), 0);
        cyc(1, 1, 0, 8'h99, 0);
        chk("rw_full_ovf",   32'(ovf_err), 1);
        chk("rw_full_dv",    32'(data_valid), 1);
        chk("rw_full_full",  32'(full), 0);
        chk("rw_full_afull", 32'(almost_full), 1);
`ifdef ROUTER_PKT_FIFO_OCC_EN
        chk("rw_full_fill",  32'(fill_level), 15);
`endif
        repeat (15) cyc(0, 1, 0, 8'h00, 0);
        chk("rw_drained", 32'(empty), 1);
        cyc(1, 1, 0, 8'h5A, 0);
        chk("rw_empty_udf",   32'(udf_err), 1);
        chk("rw_empty_empty", 32'(empty), 0);
        cyc(0, 1, 0, 8'h00, 0);
        chk("rw_empty_byte",  32'(data_out), 32'h5A);

        // soft reset mid-packet, then a fresh packet
        cyc(0, 0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, pkt_a[i], 0);
        repeat (3) cyc(0, 1, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 1);
        chk("sr_empty", 32'(empty), 1);
        chk("sr_dout",  32'(data_out), 0);
        chk("sr_dv",    32'(data_valid), 0);
        cyc(0, 0, 1, 8'h00, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, pkt_b[i], 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 8'h00, 0);
            chk("pkt_b_byte", 32'(data_out), 32'(pkt_b[i]));
            chk("pkt_b_sop",  32'(sop), 32'(i == 0));
            chk("pkt_b_eop",  32'(eop), 32'(i == 3));
        end

        // asynchronous reset between edges during a read burst
        cyc(0, 0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, pkt_a[i], 0);
        cyc(0, 1, 0, 8'h00, 0);
        @(posedge clk);
        model_step();
        #2 rst = 1'b0;
        #1;
        chk("arst_dout",  32'(data_out), 0);
        chk("arst_flags", 32'({data_valid, sop, eop, ovf_err, udf_err}), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_full",  32'({full, almost_full}), 0);
        model_reset();
        @(negedge clk);
        compare();
        read_enb = 1'b0;
        rst = 1'b1;

        // randomized traffic with fill/drain phases and rare soft resets
        for (int i = 0; i < 3000; i++) begin
            int unsigned wp;
            int unsigned rp;
            case ((i / 200) % 3)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                default: begin wp = 60; rp = 60; end
            endcase
            cyc($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                $urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 199) == 0);
        end

        // wide build: length field 5 -> eop on the 7th byte read
        @(negedge clk);
        w_lfd = 1'b1;
        @(negedge clk);
        w_lfd = 1'b0;
        w_we  = 1'b1;
        w_din = 16'h0014;
        for (int k = 1; k < 7; k++) begin
            @(negedge clk);
            w_din = 16'(16'h1000 + k);
        end
        @(negedge clk);
        w_we = 1'b0;
        w_re = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("wide_byte", 32'(w_dout), (k == 0) ? 32'h0014 : 32'h1000 + k);
            chk("wide_dv",   32'(w_dv), 1);
            chk("wide_sop",  32'(w_sop), 32'(k == 0));
            chk("wide_eop",  32'(w_eop), 32'(k == 6));
        end
        w_re = 1'b0;
        @(negedge clk);
        chk("wide_empty", 32'(w_empty), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
